hilo_muldiv: RTL
================

// Module: hilo_muldiv
// PURPOSE
//   Execute-stage multiply/divide unit; owns the architectural HI/LO registers.
//   - Consumes the alu_funct codes 1011..1110 (MULT/MULTU/DIV/DIVU) and the MTHI/MTLO writes emitted by decode.
//   - Multiply has fixed latency; divide is iterative radix-2.
//   - Core stalls MFHI/MFLO and new MD ops while busy=1.
// PARAMETERS
//   MUL_LAT  2   cycles from accept to done for MULT/MULTU (1..4)
// PORTS
//   clk          in   1   clock, rising edge
//   resetn       in   1   asynchronous reset, active-low
//   start_valid  in   1   MD op offered this cycle
//   start_ready  out  1   unit idle, can accept (=~busy)
//   funct        in   4   1011 MULT, 1100 MULTU, 1101 DIV, 1110 DIVU
//   src_a        in   32  rs value (dividend / multiplicand)
//   src_b        in   32  rt value (divisor / multiplier)
//   flush        in   1   abort in-flight op (exception/redirect)
//   hi_we        in   1   MTHI write
//   lo_we        in   1   MTLO write
//   wdata        in   32  MTHI/MTLO data
//   hi           out  32  HI register
//   lo           out  32  LO register
//   busy         out  1   op in flight
//   done         out  1   one-cycle pulse; HI/LO updated on this same edge
// BEHAVIOUR
//   Reset: hi=lo=0, busy=0, done=0, state IDLE; resetn low mid-op discards the op.
//   Accept: start_valid & start_ready & ~flush, with funct in 1011..1110.
//     - Other funct values are ignored, and no state change occurs.
//     - Operands are latched on accept.
//   FSM IDLE -> MUL (counter=MUL_LAT) or DIV_INIT -> DIV_ITER (32 cycles) -> DIV_FIX -> IDLE.
//   MUL: 64-bit product; signed for MULT, unsigned for MULTU.
//     - Pipelined MUL_LAT stages.
//     - done in cycle accept+MUL_LAT; {hi,lo} <= product.
//   DIV:
//     - Magnitudes taken in DIV_INIT.
//     - 32 restoring iterations in DIV_ITER.
//     - Sign fix-up in DIV_FIX.
//     - done at accept+34.
//     - lo <= quotient (truncated toward zero); hi <= remainder (sign of dividend).
//   Divide boundaries:
//     - b=0: lo=FFFF_FFFF, hi=|a| with sign applied as for the normal path (DIVU: hi=a).
//     - DIV 8000_0000 / FFFF_FFFF: lo=8000_0000, hi=0.
//   Flush:
//     - Synchronous; any state -> IDLE next cycle.
//     - No done; HI/LO untouched.
//     - flush on the done cycle suppresses the update.
//   MTHI/MTLO:
//     - hi_we/lo_we write on the next edge in any state.
//     - A later done overwrites both registers.
//     - Same-cycle done and hi_we/lo_we: the done result wins.
//   busy=1 from the cycle after accept through the done cycle inclusive; start_ready=0 meanwhile.
// CONFIGURATION
//   MDU_DIV_FAST_EN defined: in DIV_INIT, if b==0 or |a|<|b|, skip DIV_ITER.
//     - lo=quotient per the rules above (0, or FFFF_FFFF for b==0); hi=remainder.
//     - done at accept+2.
//   Undefined: every divide takes exactly 34 cycles.
// STRUCTURE
//   Package mdu_pkg holds:
//     - typedef enum md_funct_t {MD_MULT=4'b1011, MD_MULTU, MD_DIV, MD_DIVU}
//     - typedef enum mdu_state_t {IDLE, MUL, DIV_INIT, DIV_ITER, DIV_FIX}
//     - localparam DIV_ITERS=32
//   Sub-module div_iter_u32: unsigned restoring divider datapath.
//     - Remainder/quotient shift registers and a 6-bit count.
//     - Driven by load/step; the FSM stays in hilo_muldiv.
// TESTING
//   - MULT FFFF_FFFD*0000_0005 -> done at cycle 2; hi=FFFF_FFFF, lo=FFFF_FFF1.
//   - MULTU FFFF_FFFF*FFFF_FFFF -> hi=FFFF_FFFE, lo=0000_0001; start_ready=0 until done.
//   - DIV FFFF_FFF9/0000_0002 -> done exactly 34 cycles after accept; lo=FFFF_FFFD, hi=FFFF_FFFF.
//     - DIV 8000_0000/FFFF_FFFF -> lo=8000_0000, hi=0.
//   - DIVU 0000_0007/0 -> lo=FFFF_FFFF, hi=0000_0007.
//     - Done at cycle 34, or at cycle 2 with MDU_DIV_FAST_EN.
//   - Flush at cycle 10 of a DIV -> no done, HI/LO unchanged, start_ready=1 next cycle.
//     - resetn pulse mid-DIV -> hi=lo=0 immediately.
//   - MTHI 1234_5678 while idle -> hi=1234_5678 next cycle.
//     - hi_we asserted on the MULT done cycle -> hi holds the product, not wdata.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: function codes, FSM states
// and small decode helpers.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_MULT  = 4'b1011,
        MD_MULTU,
        MD_DIV,
        MD_DIVU
    } md_funct_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV_INIT,
        DIV_ITER,
        DIV_FIX
    } mdu_state_t;

    localparam int DIV_ITERS = 32;

    function automatic logic is_md_funct(input logic [3:0] f);
        return (f >= MD_MULT) && (f <= MD_DIVU);
    endfunction

    function automatic logic is_mul_funct(input logic [3:0] f);
        return (f == MD_MULT) || (f == MD_MULTU);
    endfunction

    function automatic logic is_signed_funct(input logic [3:0] f);
        return (f == MD_MULT) || (f == MD_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Core-side bundle for the multiply/divide unit: op issue, flush,
// MTHI/MTLO writes and the architectural HI/LO view.
interface hilo_muldiv_if;
    logic        start_valid;
    logic        start_ready;
    logic [3:0]  funct;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start_valid, funct, src_a, src_b, flush, hi_we, lo_we, wdata,
        input  start_ready, hi, lo, busy, done
    );

    modport slave (
        input  start_valid, funct, src_a, src_b, flush, hi_we, lo_we, wdata,
        output start_ready, hi, lo, busy, done
    );
endinterface

// File: rtl/hilo_muldiv_div_iter_u32.sv
// Unsigned radix-2 restoring divider datapath; one quotient bit per step.
// Sequencing (load/step) is owned by the enclosing FSM.
module div_iter_u32 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic [5:0]  count
);
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] shifted;
    logic [33:0] diff;

    // Dividend bits are consumed from quo_q's MSB as quotient bits enter its LSB.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        shifted = {rem_q, quo_q[31]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
        end else if (step) begin
            rem_d = diff[33] ? shifted[31:0] : diff[31:0];
            quo_d = {quo_q[30:0], ~diff[33]};
            cnt_d = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign count     = cnt_q;
endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide unit owning HI/LO. Defining MDU_DIV_FAST_EN
// lets divides with b==0 or |a|<|b| bypass the iterative loop.
module hilo_muldiv
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic          clk,
    input  logic          resetn,
    hilo_muldiv_if.slave  md
);
    mdu_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        skip_q, skip_d;
    logic        sgn_q, sgn_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        accept, mul_accept, commit, mul_sx, div_skip;
    logic        div_load, div_step;
    logic [31:0] abs_a, abs_b, div_quo, div_rem, q_mag, r_mag, div_hi, div_lo;
    logic [5:0]  div_cnt;
    logic [63:0] mul_prod, res;
    logic [63:0] mul_pipe_q [MUL_LAT];
    logic [63:0] mul_pipe_d [MUL_LAT];

    assign accept     = (state_q == IDLE) && md.start_valid && !md.flush && is_md_funct(md.funct);
    assign mul_accept = accept && is_mul_funct(md.funct);
    assign commit     = last_q && !md.flush;

    // Product is formed from the live operands in the accept cycle, then delayed.
    assign mul_sx   = (md.funct == MD_MULT);
    assign mul_prod = $signed({{32{mul_sx & md.src_a[31]}}, md.src_a})
                    * $signed({{32{mul_sx & md.src_b[31]}}, md.src_b});

    for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_mul
        if (gi == 0) begin : g_first
            assign mul_pipe_d[gi] = mul_accept ? mul_prod : mul_pipe_q[gi];
        end else begin : g_next
            assign mul_pipe_d[gi] = mul_pipe_q[gi-1];
        end
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) mul_pipe_q[gi] <= '0;
            else         mul_pipe_q[gi] <= mul_pipe_d[gi];
        end
    end

    assign abs_a = (sgn_q && a_q[31]) ? -a_q : a_q;
    assign abs_b = (sgn_q && b_q[31]) ? -b_q : b_q;

`ifdef MDU_DIV_FAST_EN
    assign div_skip = (b_q == 32'd0) || (abs_a < abs_b);
`else
    assign div_skip = 1'b0;
`endif

    div_iter_u32 u_div (
        .clk       (clk),
        .resetn    (resetn),
        .load      (div_load),
        .step      (div_step),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .count     (div_cnt)
    );

    // Divide-by-zero forces an all-ones quotient regardless of operand signs.
    assign q_mag  = skip_q ? 32'd0 : div_quo;
    assign r_mag  = skip_q ? abs_a : div_rem;
    assign div_lo = (b_q == 32'd0) ? 32'hFFFF_FFFF
                  : ((sgn_q && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag);
    assign div_hi = (sgn_q && a_q[31]) ? -r_mag : r_mag;
    assign res    = (state_q == MUL) ? mul_pipe_q[MUL_LAT-1] : {div_hi, div_lo};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        skip_d   = skip_q;
        sgn_d    = sgn_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = md.hi_we ? md.wdata : hi_q;
        lo_d     = md.lo_we ? md.wdata : lo_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d   = md.src_a;
                    b_d   = md.src_b;
                    sgn_d = is_signed_funct(md.funct);
                    if (is_mul_funct(md.funct)) begin
                        state_d = MUL;
                        cnt_d   = 3'(MUL_LAT - 1);
                        last_d  = (MUL_LAT == 1);
                    end else begin
                        state_d = DIV_INIT;
                    end
                end
            end
            MUL: begin
                if (last_q) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q - 3'd1;
                    last_d = (cnt_q == 3'd1);
                end
            end
            DIV_INIT: begin
                div_load = 1'b1;
                skip_d   = div_skip;
                state_d  = div_skip ? DIV_FIX : DIV_ITER;
                last_d   = div_skip;
            end
            DIV_ITER: begin
                div_step = 1'b1;
                if (div_cnt == 6'(DIV_ITERS - 1)) begin
                    state_d = DIV_FIX;
                    last_d  = 1'b1;
                end
            end
            DIV_FIX: begin
                state_d = IDLE;
                last_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                last_d  = 1'b0;
            end
        endcase
        if (commit) begin
            hi_d = res[63:32];
            lo_d = res[31:0];
        end
        if (md.flush) begin
            state_d = IDLE;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            skip_q  <= 1'b0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            skip_q  <= skip_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.start_ready = (state_q == IDLE);
    assign md.busy        = (state_q != IDLE);
    assign md.done        = last_q && !md.flush;
    assign md.hi          = hi_q;
    assign md.lo          = lo_q;
endmodule
